// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator: per-channel OFF/ON/BLINK/BURST modes timed
// by a shared tick prescaler; led/busy are decoded from registered state only.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | channel dark, no pattern running (OFF, finished BURST, empty)
// ON_PH  | LED lit; timed in BLINK/BURST, held forever in ON mode
// OFF_PH | LED dark, timing the off part of a BLINK/BURST cycle
module led_pattern_gen #(
  parameter int CLK_HZ  = 27000000,
  parameter int TICK_HZ = 1000,
  parameter int N_CH    = 4,
  parameter int TW      = 16,
  parameter int RW      = 8,
  localparam int CW     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cfg_we,
  input  logic [CW-1:0]   cfg_ch,
  input  logic [1:0]      cfg_mode,
  input  logic [TW-1:0]   cfg_on,
  input  logic [TW-1:0]   cfg_off,
  input  logic [RW-1:0]   cfg_reps,
  output logic [N_CH-1:0] led,
  output logic [N_CH-1:0] busy,
  output logic [N_CH-1:0] done
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {IDLE, ON_PH, OFF_PH} state_t;
  typedef enum logic [1:0] {M_OFF, M_ON, M_BLINK, M_BURST} mode_t;

  logic [PW-1:0] pre_q, pre_d;
  logic          tick;

  state_t        state_q [N_CH];
  state_t        state_d [N_CH];
  mode_t         mode_q  [N_CH];
  mode_t         mode_d  [N_CH];
  logic [TW-1:0] on_q    [N_CH];
  logic [TW-1:0] on_d    [N_CH];
  logic [TW-1:0] off_q   [N_CH];
  logic [TW-1:0] off_d   [N_CH];
  logic [TW-1:0] cnt_q   [N_CH];
  logic [TW-1:0] cnt_d   [N_CH];
  logic [RW-1:0] rem_q   [N_CH];
  logic [RW-1:0] rem_d   [N_CH];
  logic [N_CH-1:0] done_q, done_d;
  logic [N_CH-1:0] cyc_end;
  logic            cfg_hit;

  // With DIV=1 the count is pinned at 0, so tick stays high every cycle.
  assign tick    = (pre_q == PW'(DIV - 1));
  assign cfg_hit = cfg_we && (int'(cfg_ch) < N_CH);

  always_comb begin
    pre_d   = tick ? '0 : pre_q + PW'(1);
    done_d  = '0;
    cyc_end = '0;
    for (int i = 0; i < N_CH; i++) begin
      state_d[i] = state_q[i];
      mode_d[i]  = mode_q[i];
      on_d[i]    = on_q[i];
      off_d[i]   = off_q[i];
      cnt_d[i]   = cnt_q[i];
      rem_d[i]   = rem_q[i];

      if (cfg_hit && (int'(cfg_ch) == i)) begin
        mode_d[i] = mode_t'(cfg_mode);
        on_d[i]   = cfg_on;
        off_d[i]  = cfg_off;
        rem_d[i]  = cfg_reps;
        cnt_d[i]  = '0;
        case (mode_t'(cfg_mode))
          M_OFF: state_d[i] = IDLE;
          M_ON:  state_d[i] = ON_PH;
          default: begin
            if (cfg_on != '0)       state_d[i] = ON_PH;
            else if (cfg_off != '0) state_d[i] = OFF_PH;
            else                    state_d[i] = IDLE;
            // An empty burst finishes immediately with its done pulse.
            if ((mode_t'(cfg_mode) == M_BURST) &&
                ((cfg_reps == '0) || ((cfg_on == '0) && (cfg_off == '0)))) begin
              state_d[i] = IDLE;
              done_d[i]  = 1'b1;
            end
          end
        endcase
      end else if (tick && (state_q[i] != IDLE) &&
                   ((mode_q[i] == M_BLINK) || (mode_q[i] == M_BURST))) begin
        case (state_q[i])
          ON_PH: begin
            if (cnt_q[i] == on_q[i] - TW'(1)) begin
              cnt_d[i] = '0;
              if (off_q[i] != '0)         state_d[i] = OFF_PH;
              else if (mode_q[i] == M_BURST) cyc_end[i] = 1'b1;
            end else begin
              cnt_d[i] = cnt_q[i] + TW'(1);
            end
          end
          OFF_PH: begin
            if (cnt_q[i] == off_q[i] - TW'(1)) begin
              cnt_d[i] = '0;
              if (mode_q[i] == M_BURST) cyc_end[i] = 1'b1;
              else if (on_q[i] != '0)   state_d[i] = ON_PH;
            end else begin
              cnt_d[i] = cnt_q[i] + TW'(1);
            end
          end
          default: ;
        endcase

        if (cyc_end[i]) begin
          if (rem_q[i] == RW'(1)) begin
            state_d[i] = IDLE;
            done_d[i]  = 1'b1;
          end else begin
            rem_d[i]   = rem_q[i] - RW'(1);
            state_d[i] = (on_q[i] != '0) ? ON_PH : OFF_PH;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q  <= '0;
      done_q <= '0;
      for (int i = 0; i < N_CH; i++) begin
        state_q[i] <= IDLE;
        mode_q[i]  <= M_OFF;
        on_q[i]    <= '0;
        off_q[i]   <= '0;
        cnt_q[i]   <= '0;
        rem_q[i]   <= '0;
      end
    end else begin
      pre_q  <= pre_d;
      done_q <= done_d;
      for (int i = 0; i < N_CH; i++) begin
        state_q[i] <= state_d[i];
        mode_q[i]  <= mode_d[i];
        on_q[i]    <= on_d[i];
        off_q[i]   <= off_d[i];
        cnt_q[i]   <= cnt_d[i];
        rem_q[i]   <= rem_d[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      led[i]  = (state_q[i] == ON_PH);
      busy[i] = (state_q[i] != IDLE) &&
                ((mode_q[i] == M_BLINK) || (mode_q[i] == M_BURST));
    end
  end

  assign done = done_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen: a DIV=1 four-channel instance for pattern
// timing and a DIV=4 three-channel instance for prescaled timing and bad-channel writes.
module tb_led_pattern_gen;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, we_a;
  logic [1:0]  ch_a, mode_a;
  logic [15:0] on_a, off_a;
  logic [7:0]  reps_a;
  logic [3:0]  led_a, busy_a, done_a;

  logic        rst_d, we_d;
  logic [1:0]  ch_d, mode_d;
  logic [15:0] on_d, off_d;
  logic [7:0]  reps_d;
  logic [2:0]  led_d, busy_d, done_d;

  int n_checks = 0;
  int n_pass   = 0;

  led_pattern_gen #(.CLK_HZ(1000), .TICK_HZ(1000), .N_CH(4), .TW(16), .RW(8)) dut_a (
    .clk(clk), .rst(rst_a), .cfg_we(we_a), .cfg_ch(ch_a), .cfg_mode(mode_a),
    .cfg_on(on_a), .cfg_off(off_a), .cfg_reps(reps_a),
    .led(led_a), .busy(busy_a), .done(done_a));

  led_pattern_gen #(.CLK_HZ(4000), .TICK_HZ(1000), .N_CH(3), .TW(16), .RW(8)) dut_d (
    .clk(clk), .rst(rst_d), .cfg_we(we_d), .cfg_ch(ch_d), .cfg_mode(mode_d),
    .cfg_on(on_d), .cfg_off(off_d), .cfg_reps(reps_d),
    .led(led_d), .busy(busy_d), .done(done_d));

  localparam logic [1:0] OFF = 2'd0, ON = 2'd1, BLINK = 2'd2, BURST = 2'd3;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_a(input logic [1:0] ch, input logic [1:0] mode,
                         input logic [15:0] on, input logic [15:0] off, input logic [7:0] reps);
    we_a = 1'b1; ch_a = ch; mode_a = mode; on_a = on; off_a = off; reps_a = reps;
    step();
    we_a = 1'b0;
  endtask

  task automatic write_d(input logic [1:0] ch, input logic [1:0] mode,
                         input logic [15:0] on, input logic [15:0] off, input logic [7:0] reps);
    we_d = 1'b1; ch_d = ch; mode_d = mode; on_d = on; off_d = off; reps_d = reps;
    step();
    we_d = 1'b0;
  endtask

  task automatic test_reset();
    rst_a = 1'b1; rst_d = 1'b1;
    step(); step();
    rst_a = 1'b0; rst_d = 1'b0;
    n_checks++; if (led_a !== 4'b0000)  $display("FAIL reset_led got=%b exp=0000", led_a);  else n_pass++;
    n_checks++; if (busy_a !== 4'b0000) $display("FAIL reset_busy got=%b exp=0000", busy_a); else n_pass++;
    n_checks++; if (done_a !== 4'b0000) $display("FAIL reset_done got=%b exp=0000", done_a); else n_pass++;
    n_checks++; if (led_d !== 3'b000)   $display("FAIL reset_led_d got=%b exp=000", led_d);  else n_pass++;
    write_a(2'd0, ON, 16'd0, 16'd0, 8'd0);
    n_checks++; if (led_a !== 4'b0001)  $display("FAIL latency_on got=%b exp=0001", led_a);  else n_pass++;
    n_checks++; if (busy_a !== 4'b0000) $display("FAIL on_busy got=%b exp=0000", busy_a);    else n_pass++;
    write_a(2'd0, OFF, 16'd0, 16'd0, 8'd0);
    n_checks++; if (led_a !== 4'b0000)  $display("FAIL latency_off got=%b exp=0000", led_a); else n_pass++;
  endtask

  task automatic test_blink();
    logic exp;
    write_a(2'd0, BLINK, 16'd3, 16'd2, 8'd0);
    for (int c = 0; c < 20; c++) begin
      exp = ((c % 5) < 3);
      n_checks++; if (led_a !== {3'b000, exp}) $display("FAIL blink_led c=%0d got=%b exp=%b", c, led_a, {3'b000, exp}); else n_pass++;
      n_checks++; if (busy_a !== 4'b0001) $display("FAIL blink_busy c=%0d got=%b exp=0001", c, busy_a); else n_pass++;
      step();
    end
    write_a(2'd0, OFF, 16'd0, 16'd0, 8'd0);
  endtask

  task automatic test_burst();
    logic [8:0] pat;
    logic       exp_led;
    int         pulses;
    pat = 9'b110110110;
    pulses = 0;
    write_a(2'd1, BURST, 16'd2, 16'd1, 8'd3);
    for (int c = 0; c < 14; c++) begin
      exp_led = (c < 9) ? pat[8 - c] : 1'b0;
      n_checks++; if (led_a !== {2'b00, exp_led, 1'b0}) $display("FAIL burst_led c=%0d got=%b exp=%b", c, led_a, {2'b00, exp_led, 1'b0}); else n_pass++;
      n_checks++; if (done_a[1] !== (c == 9)) $display("FAIL burst_done c=%0d got=%b exp=%b", c, done_a[1], (c == 9)); else n_pass++;
      n_checks++; if (busy_a[1] !== (c < 9)) $display("FAIL burst_busy c=%0d got=%b exp=%b", c, busy_a[1], (c < 9)); else n_pass++;
      if (done_a[1] === 1'b1) pulses++;
      step();
    end
    n_checks++; if (pulses != 1) $display("FAIL burst_pulse_count got=%0d exp=1", pulses); else n_pass++;
  endtask

  task automatic test_boundary();
    write_a(2'd2, BURST, 16'd3, 16'd2, 8'd0);
    n_checks++; if (done_a !== 4'b0100) $display("FAIL reps0_done got=%b exp=0100", done_a); else n_pass++;
    n_checks++; if (led_a !== 4'b0000)  $display("FAIL reps0_led got=%b exp=0000", led_a);   else n_pass++;
    step();
    n_checks++; if (done_a !== 4'b0000) $display("FAIL reps0_done_drop got=%b exp=0000", done_a); else n_pass++;

    write_a(2'd3, BLINK, 16'd0, 16'd0, 8'd0);
    n_checks++; if (led_a[3] !== 1'b0)  $display("FAIL zero_blink_led got=%b exp=0", led_a[3]); else n_pass++;
    n_checks++; if (busy_a !== 4'b0000) $display("FAIL zero_blink_busy got=%b exp=0000", busy_a); else n_pass++;

    write_a(2'd3, BURST, 16'd0, 16'd0, 8'd5);
    n_checks++; if (done_a !== 4'b1000) $display("FAIL zero_burst_done got=%b exp=1000", done_a); else n_pass++;

    // off=0 burst: one continuous on of reps*on = 6 cycles
    write_a(2'd2, BURST, 16'd2, 16'd0, 8'd3);
    for (int c = 0; c < 8; c++) begin
      n_checks++; if (led_a[2] !== (c < 6)) $display("FAIL offzero_led c=%0d got=%b exp=%b", c, led_a[2], (c < 6)); else n_pass++;
      n_checks++; if (done_a[2] !== (c == 6)) $display("FAIL offzero_done c=%0d got=%b exp=%b", c, done_a[2], (c == 6)); else n_pass++;
      step();
    end

    // on=0 burst: dark, two off cycles of 2 ticks then done
    write_a(2'd3, BURST, 16'd0, 16'd2, 8'd2);
    for (int c = 0; c < 6; c++) begin
      n_checks++; if (led_a[3] !== 1'b0) $display("FAIL onzero_led c=%0d got=%b exp=0", c, led_a[3]); else n_pass++;
      n_checks++; if (busy_a[3] !== (c < 4)) $display("FAIL onzero_busy c=%0d got=%b exp=%b", c, busy_a[3], (c < 4)); else n_pass++;
      n_checks++; if (done_a[3] !== (c == 4)) $display("FAIL onzero_done c=%0d got=%b exp=%b", c, done_a[3], (c == 4)); else n_pass++;
      step();
    end
  endtask

  task automatic test_midpattern();
    int pulses;
    write_a(2'd0, BLINK, 16'd5, 16'd5, 8'd0);
    step(); step(); step();
    write_a(2'd0, ON, 16'd0, 16'd0, 8'd0);
    for (int c = 0; c < 10; c++) begin
      n_checks++; if (led_a[0] !== 1'b1) $display("FAIL reconf_on_led c=%0d got=%b exp=1", c, led_a[0]); else n_pass++;
      step();
    end
    n_checks++; if (busy_a[0] !== 1'b0) $display("FAIL reconf_on_busy got=%b exp=0", busy_a[0]); else n_pass++;

    pulses = 0;
    write_a(2'd1, BURST, 16'd2, 16'd1, 8'd2);
    step(); step();
    write_a(2'd1, OFF, 16'd0, 16'd0, 8'd0);
    for (int c = 0; c < 10; c++) begin
      if (done_a[1] === 1'b1) pulses++;
      n_checks++; if (led_a[1] !== 1'b0) $display("FAIL abort_led c=%0d got=%b exp=0", c, led_a[1]); else n_pass++;
      step();
    end
    n_checks++; if (pulses != 0) $display("FAIL abort_done_pulses got=%0d exp=0", pulses); else n_pass++;

    // reset wins over a same-cycle write
    rst_a = 1'b1;
    write_a(2'd2, ON, 16'd0, 16'd0, 8'd0);
    rst_a = 1'b0;
    n_checks++; if (led_a !== 4'b0000) $display("FAIL rst_over_we got=%b exp=0000", led_a); else n_pass++;
    step();
    n_checks++; if (led_a !== 4'b0000) $display("FAIL rst_over_we_after got=%b exp=0000", led_a); else n_pass++;
  endtask

  task automatic test_div4();
    int  highs, rises, first_rise, second_rise;
    logic prev;
    bit  found;
    write_d(2'd0, BLINK, 16'd2, 16'd2, 8'd0);
    for (int c = 0; c < 40; c++) step();
    highs = 0; rises = 0; first_rise = -1; second_rise = -1;
    prev = led_d[0];
    for (int c = 0; c < 32; c++) begin
      step();
      if (led_d[0] === 1'b1) highs++;
      if (led_d[0] === 1'b1 && prev === 1'b0) begin
        rises++;
        if (first_rise < 0) first_rise = c;
        else if (second_rise < 0) second_rise = c;
      end
      prev = led_d[0];
    end
    n_checks++; if (highs != 16) $display("FAIL div4_high_count got=%0d exp=16", highs); else n_pass++;
    n_checks++; if (rises != 2) $display("FAIL div4_rises got=%0d exp=2", rises); else n_pass++;
    n_checks++; if ((second_rise - first_rise) != 16) $display("FAIL div4_period got=%0d exp=16", second_rise - first_rise); else n_pass++;

    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      if (led_d[0] === 1'b1) found = 1'b1;
      else step();
    end
    n_checks++; if (!found) $display("FAIL div4_wait_on got=timeout exp=led_high"); else n_pass++;
    rst_d = 1'b1;
    step();
    rst_d = 1'b0;
    n_checks++; if (led_d !== 3'b000) $display("FAIL div4_rst_led got=%b exp=000", led_d); else n_pass++;
    n_checks++; if (busy_d !== 3'b000) $display("FAIL div4_rst_busy got=%b exp=000", busy_d); else n_pass++;

    write_d(2'd3, ON, 16'd0, 16'd0, 8'd0);
    n_checks++; if (led_d !== 3'b000) $display("FAIL bad_ch_led got=%b exp=000", led_d); else n_pass++;
    write_d(2'd3, BURST, 16'd0, 16'd0, 8'd0);
    n_checks++; if (done_d !== 3'b000) $display("FAIL bad_ch_done got=%b exp=000", done_d); else n_pass++;
    write_d(2'd2, ON, 16'd0, 16'd0, 8'd0);
    n_checks++; if (led_d !== 3'b100) $display("FAIL good_ch_led got=%b exp=100", led_d); else n_pass++;
  endtask

  initial begin
    rst_a = 1'b1; we_a = 1'b0; ch_a = '0; mode_a = '0; on_a = '0; off_a = '0; reps_a = '0;
    rst_d = 1'b1; we_d = 1'b0; ch_d = '0; mode_d = '0; on_d = '0; off_d = '0; reps_d = '0;
    #1;
    test_reset();
    test_blink();
    test_burst();
    test_boundary();
    test_midpattern();
    test_div4();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
